// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states
// and the request legality check used at accept time.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_WR_WAIT  = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  // A request is rejected without touching memory when its size is illegal
  // or its address is not naturally aligned for that size.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      SIZE_ILL:  bad = 1'b1;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Big-endian lane handling for sub-word accesses: extracts and extends the
// addressed byte/halfword for loads, and merges store data into a read word.
module byte_lane_unit
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select (byte 0 is the most significant) plus extend and merge.
  always_comb begin
    byte_v     = 8'h00;
    half_v     = 16'h0000;
    load_data  = word_in;
    merge_data = word_in;
    case (lane)
      2'd0:    byte_v = word_in[31:24];
      2'd1:    byte_v = word_in[23:16];
      2'd2:    byte_v = word_in[15:8];
      default: byte_v = word_in[7:0];
    endcase
    half_v = lane[1] ? word_in[15:0] : word_in[31:16];
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
        case (lane)
          2'd0:    merge_data[31:24] = wdata[7:0];
          2'd1:    merge_data[23:16] = wdata[7:0];
          2'd2:    merge_data[15:8]  = wdata[7:0];
          default: merge_data[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        load_data = {{16{sign_ext & half_v[15]}}, half_v};
        if (lane[1]) merge_data[15:0]  = wdata[15:0];
        else         merge_data[31:16] = wdata[15:0];
      end
      default: begin
        load_data  = word_in;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the word-only data memory. Sub-word loads extract a lane from
// the read word; sub-word stores do read-modify-write. Completion of each
// memory access is signalled by a toggle of mem_vivi.
//
// Handshake: a request is accepted on a posedge where req_valid & req_ready;
// req_ready is high only in IDLE outside reset. The response is a single
// resp_valid cycle with no back-pressure; the next request may be accepted
// on the cycle after that pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset0,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_write_enable,
  output logic        mem_visit,
  input  logic [31:0] mem_outp,
  input  logic        mem_valid,
  input  logic        mem_vivi,
  output logic [2:0]  dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic        vivi_ref_q, vivi_ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        visit_q, visit_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rvalid_q, rvalid_d;
  logic        rerror_q, rerror_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        toggled;

  byte_lane_unit u_lane (
    .word_in    (mem_outp),
    .size       (size_q),
    .lane       (lane_q),
    .sign_ext   (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign toggled          = (mem_vivi != vivi_ref_q);
  assign req_ready        = (state_q == S_IDLE) && !reset0;
  // A visit seen by the memory during reset would clear it, so gate it here.
  assign mem_visit        = visit_q & ~reset0;
  assign mem_write_enable = we_q & ~reset0;
  assign mem_addr         = addr_q;
  assign mem_data         = data_q;
  assign resp_valid       = rvalid_q;
  assign resp_error       = rerror_q;
  assign resp_rdata       = rdata_q;
  assign dbg_state        = state_q;

  // Next-state and registered-output logic; strobes default low each cycle.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    signed_d   = signed_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    vivi_ref_d = vivi_ref_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    visit_d    = 1'b0;
    we_d       = 1'b0;
    rvalid_d   = 1'b0;
    rerror_d   = 1'b0;
    rdata_d    = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata;
          addr_d   = {req_addr[31:2], 2'b00};
          if (req_bad(req_size, req_addr[1:0])) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rerror_d = 1'b1;
          end else if (!req_write || req_size != SIZE_WORD) begin
            state_d    = S_RD_ISSUE;
            visit_d    = 1'b1;
            vivi_ref_d = mem_vivi;
            cnt_d      = '0;
          end else begin
            state_d    = S_WR_ISSUE;
            visit_d    = 1'b1;
            we_d       = 1'b1;
            data_d     = req_wdata;
            vivi_ref_d = mem_vivi;
            cnt_d      = '0;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_RD_WAIT: begin
        if (toggled) begin
          if (!mem_valid) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rerror_d = 1'b1;
          end else if (write_q) begin
            state_d    = S_WR_ISSUE;
            visit_d    = 1'b1;
            we_d       = 1'b1;
            data_d     = merge_data;
            vivi_ref_d = mem_vivi;
            cnt_d      = '0;
          end else begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rdata_d  = load_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rerror_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_WAIT: begin
        if (toggled) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rerror_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset0) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      signed_q   <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
      vivi_ref_q <= 1'b0;
      cnt_q      <= '0;
      visit_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      rvalid_q   <= 1'b0;
      rerror_q   <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      vivi_ref_q <= vivi_ref_d;
      cnt_q      <= cnt_d;
      visit_q    <= visit_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rvalid_q   <= rvalid_d;
      rerror_q   <= rerror_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a negedge data-memory model, a byte-array
// reference model that predicts each response, and a monitor that checks
// responses against an expected queue.
module tb_mem_access_unit;

  localparam int TO = 4;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          vbase;
    int          wbase;
    int          nvis;
    int          nwr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset0 = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_write_enable;
  logic        mem_visit;
  logic [31:0] mem_outp = 32'h0;
  logic        mem_valid = 1'b1;
  logic        mem_vivi = 1'b0;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vis_total = 0;
  int wr_total = 0;
  logic prev_visit = 1'b0;
  logic freeze = 1'b0;

  logic [31:0] dmem [0:255];
  logic [31:0] ref_mem [0:255];
  exp_t exp_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset0(reset0),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write_enable(mem_write_enable), .mem_visit(mem_visit),
    .mem_outp(mem_outp), .mem_valid(mem_valid), .mem_vivi(mem_vivi),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acts on the negedge of a visit cycle, then toggles vivi.
  always @(negedge clock) begin
    if (reset0 && mem_visit) chk("visit_in_reset", 32'(mem_visit), 32'd0);
    if (mem_visit && !freeze) begin
      if (mem_write_enable) dmem[mem_addr[9:2]] = mem_data;
      else mem_outp <= dmem[mem_addr[9:2]];
      mem_vivi <= ~mem_vivi;
    end
  end

  // Monitor: counts visits and checks every response against the queue head.
  always @(negedge clock) begin
    exp_t e;
    if (mem_visit) begin
      chk("visit_one_cycle", 32'(prev_visit), 32'd0);
      vis_total++;
      if (mem_write_enable) wr_total++;
    end
    prev_visit = mem_visit;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_error", 32'(resp_error), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("visit_count", 32'(vis_total - e.vbase), 32'(e.nvis));
        chk("write_count", 32'(wr_total - e.wbase), 32'(e.nwr));
      end
    end
  end

  // Reference model helpers: memory seen as 4 big-endian bytes per word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input int k);
    return w[31 - 8*k -: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input logic [7:0] b);
    logic [7:0] bytes [4];
    for (int i = 0; i < 4; i++) bytes[i] = get_byte(w, i);
    bytes[k] = b;
    return {bytes[0], bytes[1], bytes[2], bytes[3]};
  endfunction

  // Driver: waits for ready, presents one request for the accept edge.
  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input exp_t e, input logic push);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    e.acc = cyc + 1;
    e.vbase = vis_total;
    e.wbase = wr_total;
    if (push) exp_q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Predict the response from the access rules, update the model, drive.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int k = int'(a[1:0]);
    int idx = int'(a[9:2]);
    logic [31:0] word = ref_mem[idx];
    logic [15:0] h;
    logic bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && k != 0);
    e.err = 1'b0; e.rdata = 32'h0; e.lat = 3; e.nvis = 1; e.nwr = 0; e.acc = 0; e.vbase = 0; e.wbase = 0;
    if (bad) begin
      e.err = 1'b1; e.lat = 1; e.nvis = 0;
    end else if (!w) begin
      if (sz == 2'd0) e.rdata = sg ? 32'(signed'(get_byte(word, k))) : 32'(get_byte(word, k));
      else if (sz == 2'd1) begin
        h = {get_byte(word, k), get_byte(word, k + 1)};
        e.rdata = sg ? 32'(signed'(h)) : 32'(h);
      end else e.rdata = word;
      if (freeze) begin
        e.err = 1'b1; e.rdata = 32'h0; e.lat = 2 + TO;
      end else if (!mem_valid) begin
        e.err = 1'b1; e.rdata = 32'h0;
      end
    end else if (sz == 2'd2) begin
      e.nwr = 1;
      ref_mem[idx] = wd;
    end else begin
      e.lat = 5; e.nvis = 2; e.nwr = 1;
      if (sz == 2'd0) ref_mem[idx] = put_byte(word, k, wd[7:0]);
      else ref_mem[idx] = put_byte(put_byte(word, k, wd[15:8]), k + 1, wd[7:0]);
    end
    drive_req(w, sz, sg, a, wd, e, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("resp_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    exp_t dummy;
    logic [1:0] sz;
    logic [31:0] a;
    dummy = '{err: 1'b0, rdata: 32'h0, lat: 0, acc: 0, vbase: 0, wbase: 0, nvis: 0, nwr: 0};
    for (int i = 0; i < 256; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_visit", 32'(mem_visit), 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data", mem_data, 32'h0);
    reset0 = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_state", 32'(dbg_state), 32'd0);

    // Word store and word load
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF); wait_done();
    chk("mem_word_100", dmem[8'h40], 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0); wait_done();
    // Sub-word loads
    issue(1'b0, 2'd0, 1'b1, 32'h101, 32'h0); wait_done();
    issue(1'b0, 2'd0, 1'b0, 32'h101, 32'h0); wait_done();
    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0); wait_done();
    // Half store read-modify-write
    issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234); wait_done();
    chk("mem_word_rmw", dmem[8'h40], 32'hDEAD1234);
    // Misaligned and illegal size
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0); wait_done();
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0); wait_done();
    issue(1'b1, 2'd1, 1'b0, 32'h103, 32'h0); wait_done();
    // Frozen memory: timeout
    freeze = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0); wait_done();
    freeze = 1'b0;
    @(negedge clock);
    chk("ready_after_timeout", 32'(req_ready), 32'd1);
    // Memory flags an access as invalid
    mem_valid = 1'b0;
    issue(1'b0, 2'd0, 1'b0, 32'h108, 32'h0); wait_done();
    mem_valid = 1'b1;

    // Reset during WR_WAIT: the write already reached memory, no response
    drive_req(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, dummy, 1'b0);
    ref_mem[8'h80] = 32'hCAFEF00D;
    @(negedge clock);
    chk("wr_wait_state", 32'(dbg_state), 32'd4);
    reset0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset_visit", 32'(mem_visit), 32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    end
    reset0 = 1'b0;
    @(negedge clock);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    chk("post_reset_state", 32'(dbg_state), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0); wait_done();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 1) == 0) wait_done();
    end
    wait_done();
    for (int i = 0; i < 256; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
